// File: rtl/ahb_ext_pkg.sv
// Shared AHB extension-bus codes, slot-field position and default-slave state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ahb_ext_pkg;

  // HTRANS transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP codes
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Slave slot number lives in HADDR[19:16]
  localparam int SLOT_LSB = 16;
  localparam int SLOT_MSB = 19;
  localparam int SLOT_W   = SLOT_MSB - SLOT_LSB + 1;

  // Built-in default slave states
  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // NONSEQ and SEQ are the only transfer types that demand a real response
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers (and, with AHB_DEC_TIMEOUT_EN, hung slaves) with a two-cycle ERROR.
// Latency: ERROR occupies exactly two data-phase cycles (HREADY low, then high), outputs registered.
// Backpressure: holds the bus with hready_o=0 during ERR1; relies on the bus HREADY qualifying err_cap_i.
module ahb_default_slave
  import ahb_ext_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       AHB_HCLK,
  input  logic       AHB_HRESETn,
  input  logic       err_cap_i,
`ifdef AHB_DEC_TIMEOUT_EN
  input  logic       slv_wait_i,
  output logic       timeout_o,
`endif
  output logic       busy_o,
  output logic       hready_o,
  output logic [1:0] hresp_o
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_cfg_err
    $error("ahb_default_slave: TIMEOUT_CYC must be 1..65535");
  end

  ds_state_t state_q;
  logic      to_fire;

`ifdef AHB_DEC_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The limit fires on the edge that would bring the count to TIMEOUT_CYC
  assign timeout_o = slv_wait_i && (cnt_q == CNT_LIM) && (state_q == DS_IDLE);
  assign to_fire   = timeout_o;

  // Count consecutive slave wait cycles; any ready cycle or a timeout restarts it
  always_comb begin
    cnt_d = '0;
    if (slv_wait_i && !timeout_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Wait counter register
  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
    if (!AHB_HRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // ERROR sequencer with registered response outputs
  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
    if (!AHB_HRESETn) begin
      state_q  <= DS_IDLE;
      busy_o   <= 1'b0;
      hready_o <= 1'b1;
      hresp_o  <= HRESP_OKAY;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (err_cap_i || to_fire) begin
            state_q  <= DS_ERR1;
            busy_o   <= 1'b1;
            hready_o <= 1'b0;
            hresp_o  <= HRESP_ERROR;
          end
        end
        DS_ERR1: begin
          state_q  <= DS_ERR2;
          busy_o   <= 1'b1;
          hready_o <= 1'b1;
          hresp_o  <= HRESP_ERROR;
        end
        DS_ERR2: begin
          // A new unmapped transfer accepted on the final ERROR cycle chains straight into ERR1
          if (err_cap_i) begin
            state_q  <= DS_ERR1;
            busy_o   <= 1'b1;
            hready_o <= 1'b0;
            hresp_o  <= HRESP_ERROR;
          end else begin
            state_q  <= DS_IDLE;
            busy_o   <= 1'b0;
            hready_o <= 1'b1;
            hresp_o  <= HRESP_OKAY;
          end
        end
        default: begin
          state_q  <= DS_IDLE;
          busy_o   <= 1'b0;
          hready_o <= 1'b1;
          hresp_o  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_ext_decoder_mux.sv
// AHB extension-bus address decoder + response mux with built-in default slave; optional hung-slave timeout under AHB_DEC_TIMEOUT_EN.
// Latency: zero added cycles on mapped transfers; unmapped active transfers take exactly two data-phase cycles.
// Backpressure: M_HREADY follows the data-phase owner's HREADYOUT and is broadcast to slaves as S_HREADY.
module ahb_ext_decoder_mux
  import ahb_ext_pkg::*;
#(
  parameter int SLV_NUM     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    AHB_HCLK,
  input  logic                    AHB_HRESETn,
  input  logic                    M_HSEL,
  input  logic [31:0]             M_HADDR,
  input  logic [1:0]              M_HTRANS,
  output logic [31:0]             M_HRDATA,
  output logic                    M_HREADY,
  output logic [1:0]              M_HRESP,
  output logic [SLV_NUM-1:0]      S_HSEL,
  output logic                    S_HREADY,
  input  logic [32*SLV_NUM-1:0]   S_HRDATA,
  input  logic [SLV_NUM-1:0]      S_HREADYOUT,
  input  logic [2*SLV_NUM-1:0]    S_HRESP
);

  if (SLV_NUM < 1 || SLV_NUM > 15) begin : g_cfg_err
    $error("ahb_ext_decoder_mux: SLV_NUM must be 1..15");
  end

  localparam logic [SLOT_W:0] SLV_NUM_L = (SLOT_W + 1)'(SLV_NUM);

  // Address phase
  logic [SLOT_W-1:0] a_slot;
  logic              a_map;
  logic              a_act;
  logic              err_cap;

  // Data-phase owner
  logic [SLOT_W-1:0] d_slot_q, d_slot_d;
  logic              d_map_q,  d_map_d;
  logic              d_act_q,  d_act_d;

  // Selected slave response
  logic [31:0]       sel_rdata;
  logic              sel_rdy;
  logic [1:0]        sel_resp;

  // Default slave
  logic              ds_busy;
  logic              ds_hready;
  logic [1:0]        ds_hresp;
  logic              ds_timeout;

  logic              unused_addr;

  assign a_slot      = M_HADDR[SLOT_MSB:SLOT_LSB];
  assign a_map       = ({1'b0, a_slot} < SLV_NUM_L);
  assign a_act       = M_HSEL & htrans_active(M_HTRANS);
  assign unused_addr = ^{M_HADDR[31:SLOT_MSB+1], M_HADDR[SLOT_LSB-1:0]};

  // Only an accepted active transfer to an empty slot starts the default slave
  assign err_cap     = M_HREADY & a_act & ~a_map;

  assign S_HREADY    = M_HREADY;

  // One-hot slave select straight from the master address; unmapped slots select nobody
  always_comb begin
    S_HSEL = '0;
    for (int k = 0; k < SLV_NUM; k++) begin
      if (M_HSEL && (a_slot == SLOT_W'(k))) begin
        S_HSEL[k] = 1'b1;
      end
    end
  end

  // Pick the response of the slot that owns the current data phase
  always_comb begin
    sel_rdata = '0;
    sel_rdy   = 1'b1;
    sel_resp  = HRESP_OKAY;
    for (int k = 0; k < SLV_NUM; k++) begin
      if (d_slot_q == SLOT_W'(k)) begin
        sel_rdata = S_HRDATA[32*k +: 32];
        sel_rdy   = S_HREADYOUT[k];
        sel_resp  = S_HRESP[2*k +: 2];
      end
    end
  end

  // Response to the master: default slave first, then a mapped owner, else an idle OKAY
  always_comb begin
    M_HRDATA = '0;
    M_HREADY = 1'b1;
    M_HRESP  = HRESP_OKAY;
    if (ds_busy) begin
      M_HREADY = ds_hready;
      M_HRESP  = ds_hresp;
    end else if (d_act_q && d_map_q) begin
      M_HRDATA = sel_rdata;
      M_HREADY = sel_rdy;
      M_HRESP  = sel_resp;
    end
  end

  // Advance the data-phase owner only when the bus is ready; a timeout drops the hung owner
  always_comb begin
    d_slot_d = d_slot_q;
    d_map_d  = d_map_q;
    d_act_d  = d_act_q;
    if (M_HREADY) begin
      d_slot_d = a_slot;
      d_map_d  = a_map;
      d_act_d  = a_act;
    end else if (ds_timeout) begin
      d_act_d  = 1'b0;
    end
  end

  // Data-phase owner register
  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
    if (!AHB_HRESETn) begin
      d_slot_q <= '0;
      d_map_q  <= 1'b0;
      d_act_q  <= 1'b0;
    end else begin
      d_slot_q <= d_slot_d;
      d_map_q  <= d_map_d;
      d_act_q  <= d_act_d;
    end
  end

`ifdef AHB_DEC_TIMEOUT_EN
  logic slv_wait;
  assign slv_wait = d_act_q & d_map_q & ~sel_rdy;

  ahb_default_slave #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_default_slave (
    .AHB_HCLK    (AHB_HCLK),
    .AHB_HRESETn (AHB_HRESETn),
    .err_cap_i   (err_cap),
    .slv_wait_i  (slv_wait),
    .timeout_o   (ds_timeout),
    .busy_o      (ds_busy),
    .hready_o    (ds_hready),
    .hresp_o     (ds_hresp)
  );
`else
  assign ds_timeout = 1'b0;

  ahb_default_slave #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_default_slave (
    .AHB_HCLK    (AHB_HCLK),
    .AHB_HRESETn (AHB_HRESETn),
    .err_cap_i   (err_cap),
    .busy_o      (ds_busy),
    .hready_o    (ds_hready),
    .hresp_o     (ds_hresp)
  );
`endif

endmodule

// File: tb/tb_ahb_ext_decoder_mux.sv
// Bench for ahb_ext_decoder_mux: directed AHB transfers against simple behavioural slaves.
// Expected data-phase responses are queued at issue time and checked by an independent monitor.
// Timeout scenario is built only with AHB_DEC_TIMEOUT_EN (TIMEOUT_CYC=8).
module tb_ahb_ext_decoder_mux;
  import ahb_ext_pkg::*;

  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              m_hsel;
  logic [31:0]       m_haddr;
  logic [1:0]        m_htrans;
  logic [31:0]       m_hrdata;
  logic              m_hready;
  logic [1:0]        m_hresp;
  logic [NS-1:0]     s_hsel;
  logic              s_hready;
  logic [32*NS-1:0]  s_hrdata;
  logic [NS-1:0]     s_hreadyout;
  logic [2*NS-1:0]   s_hresp;

  always #5 clk = ~clk;

  ahb_ext_decoder_mux #(
    .SLV_NUM     (NS),
    .TIMEOUT_CYC (8)
  ) dut (
    .AHB_HCLK    (clk),
    .AHB_HRESETn (rstn),
    .M_HSEL      (m_hsel),
    .M_HADDR     (m_haddr),
    .M_HTRANS    (m_htrans),
    .M_HRDATA    (m_hrdata),
    .M_HREADY    (m_hready),
    .M_HRESP     (m_hresp),
    .S_HSEL      (s_hsel),
    .S_HREADY    (s_hready),
    .S_HRDATA    (s_hrdata),
    .S_HREADYOUT (s_hreadyout),
    .S_HRESP     (s_hresp)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural slaves ----------------
  logic [31:0] slot_data [NS];
  int          slv_wait  [NS];
  bit          slv_hang  [NS];
  int          rem       [NS];

  initial begin
    slot_data[0] = 32'hA0A0_0000;
    slot_data[1] = 32'h0000_B111;
    slot_data[2] = 32'h0000_1234;
    slot_data[3] = 32'hC3C3_0003;
    for (int k = 0; k < NS; k++) begin
      slv_wait[k] = 0;
      slv_hang[k] = 1'b0;
    end
  end

  assign s_hresp = '0;

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      s_hreadyout[k]       = (rem[k] == 0);
      s_hrdata[32*k +: 32] = slot_data[k];
    end
  end

  initial begin
    for (int k = 0; k < NS; k++) rem[k] = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int k = 0; k < NS; k++) rem[k] <= 0;
      end else begin
        for (int k = 0; k < NS; k++) begin
          if (s_hready && s_hsel[k] && m_htrans[1])
            rem[k] <= slv_hang[k] ? 1 : slv_wait[k];
          else if (rem[k] != 0 && !slv_hang[k])
            rem[k] <= rem[k] - 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
    logic [1:0]  wresp;
    string       nm;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_cur;
  bit          mon_vld = 1'b0;
  int          mon_wcnt = 0;
  logic [1:0]  mon_lresp = 2'b00;

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mon_vld  = 1'b0;
        mon_wcnt = 0;
        exp_q.delete();
      end else begin
        if (mon_vld) begin
          if (!m_hready) begin
            mon_wcnt++;
            mon_lresp = m_hresp;
            check({mon_cur.nm, " S_HREADY in wait"}, 32'(s_hready), 32'd0);
            if (mon_wcnt > 60) begin
              check({mon_cur.nm, " wait bound"}, 32'(mon_wcnt), 32'(mon_cur.waits));
              mon_vld = 1'b0;
            end
          end else begin
            check({mon_cur.nm, " HRDATA"}, m_hrdata, mon_cur.rdata);
            check({mon_cur.nm, " HRESP"}, 32'(m_hresp), 32'(mon_cur.resp));
            check({mon_cur.nm, " wait cycles"}, 32'(mon_wcnt), 32'(mon_cur.waits));
            check({mon_cur.nm, " S_HREADY at done"}, 32'(s_hready), 32'd1);
            if (mon_cur.waits > 0)
              check({mon_cur.nm, " HRESP in last wait"}, 32'(mon_lresp), 32'(mon_cur.wresp));
            mon_vld = 1'b0;
          end
        end
        if (m_hready && m_hsel && m_htrans[1]) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected transfer: addr 0x%08h accepted with no expectation queued", m_haddr);
          end else begin
            mon_cur   = exp_q.pop_front();
            mon_vld   = 1'b1;
            mon_wcnt  = 0;
            mon_lresp = 2'b00;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] tr);
    m_hsel   = sel;
    m_haddr  = addr;
    m_htrans = tr;
  endtask

  task automatic wait_accept(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_hready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!m_hready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s acceptance: HREADY still 0 after %0d cycles, expected 1", nm, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic sel, input logic [31:0] addr, input logic [1:0] tr,
                      input logic [3:0] exp_sel, input logic [31:0] rd, input logic [1:0] resp,
                      input int waits, input logic [1:0] wresp, input string nm);
    exp_t e;
    drive(sel, addr, tr);
    if (sel && tr[1]) begin
      e.rdata = rd; e.resp = resp; e.waits = waits; e.wresp = wresp; e.nm = nm;
      exp_q.push_back(e);
    end
    #1;
    check({nm, " S_HSEL"}, 32'(s_hsel), 32'(exp_sel));
    wait_accept(nm);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0, HTRANS_IDLE);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_okay_idle(input string nm);
    check({nm, " HREADY"}, 32'(m_hready), 32'd1);
    check({nm, " HRESP"},  32'(m_hresp),  32'(HRESP_OKAY));
    check({nm, " HRDATA"}, m_hrdata,      32'h0);
  endtask

  task automatic reset_mid(input logic [31:0] addr, input logic [3:0] exp_sel, input string nm);
    xfer(1'b1, addr, HTRANS_NONSEQ, exp_sel, 32'h0, HRESP_OKAY, 0, HRESP_OKAY, nm);
    drive(1'b0, 32'h0, HTRANS_IDLE);
    @(negedge clk);
    check({nm, " stalled before reset"}, 32'(m_hready), 32'd0);
    #2 rstn = 1'b0;
    #1;
    check_okay_idle({nm, " in reset"});
    check({nm, " S_HREADY in reset"}, 32'(s_hready), 32'd1);
    @(posedge clk);
    #1;
    check_okay_idle({nm, " cycle after reset"});
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 32'h0003_0000, HTRANS_NONSEQ);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_okay_idle("reset state");
    check("reset S_HREADY", 32'(s_hready), 32'd1);
    check("reset S_HSEL combinational", 32'(s_hsel), 32'h8);
    drive(1'b0, 32'h0, HTRANS_IDLE);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // mapped zero-wait write
    xfer(1'b1, 32'h0001_0004, HTRANS_NONSEQ, 4'b0010, 32'h0000_B111, HRESP_OKAY, 0, HRESP_OKAY, "wr slot1");
    idle(2);

    // slot 2 stalls 3 cycles; next address to slot 0 presented during the stall
    slv_wait[2] = 3;
    xfer(1'b1, 32'h0002_000C, HTRANS_NONSEQ, 4'b0100, 32'h0000_1234, HRESP_OKAY, 3, HRESP_OKAY, "rd slot2 wait");
    xfer(1'b1, 32'h0000_0008, HTRANS_NONSEQ, 4'b0001, 32'hA0A0_0000, HRESP_OKAY, 0, HRESP_OKAY, "rd slot0 after stall");
    idle(3);
    slv_wait[2] = 0;

    // unmapped slot 5
    xfer(1'b1, 32'h0005_0000, HTRANS_NONSEQ, 4'b0000, 32'h0, HRESP_ERROR, 1, HRESP_ERROR, "unmapped slot5");
    idle(3);

    // back-to-back slot 0 then unmapped slot 7 then IDLE
    xfer(1'b1, 32'h0000_0000, HTRANS_NONSEQ, 4'b0001, 32'hA0A0_0000, HRESP_OKAY, 0, HRESP_OKAY, "b2b slot0");
    xfer(1'b1, 32'h0007_0000, HTRANS_NONSEQ, 4'b0000, 32'h0, HRESP_ERROR, 1, HRESP_ERROR, "b2b slot7");
    xfer(1'b1, 32'h0007_0000, HTRANS_IDLE,   4'b0000, 32'h0, HRESP_OKAY, 0, HRESP_OKAY, "b2b idle");
    @(negedge clk);
    check_okay_idle("b2b idle data phase");
    idle(2);

    // two unmapped transfers chained ERR2 -> ERR1
    xfer(1'b1, 32'h000F_0000, HTRANS_NONSEQ, 4'b0000, 32'h0, HRESP_ERROR, 1, HRESP_ERROR, "unmapped slotF");
    xfer(1'b1, 32'h0009_0004, HTRANS_SEQ,    4'b0000, 32'h0, HRESP_ERROR, 1, HRESP_ERROR, "unmapped slot9 seq");
    idle(4);

    // SEQ to slot 3, BUSY to slot 1, deselected NONSEQ, unmapped IDLE
    xfer(1'b1, 32'h0003_0010, HTRANS_SEQ,    4'b1000, 32'hC3C3_0003, HRESP_OKAY, 0, HRESP_OKAY, "seq slot3");
    xfer(1'b1, 32'h0001_0000, HTRANS_BUSY,   4'b0010, 32'h0, HRESP_OKAY, 0, HRESP_OKAY, "busy slot1");
    @(negedge clk);
    check_okay_idle("busy data phase");
    @(posedge clk);
    #1;
    xfer(1'b0, 32'h0002_0000, HTRANS_NONSEQ, 4'b0000, 32'h0, HRESP_OKAY, 0, HRESP_OKAY, "hsel0 slot2");
    xfer(1'b1, 32'h000C_0000, HTRANS_IDLE,   4'b0000, 32'h0, HRESP_OKAY, 0, HRESP_OKAY, "unmapped idle");
    @(negedge clk);
    check_okay_idle("unmapped idle data phase");
    idle(2);

    // asynchronous reset during ERR1 and during a slot-3 wait
    reset_mid(32'h0006_0000, 4'b0000, "reset in ERR1");
    idle(2);
    slv_wait[3] = 5;
    reset_mid(32'h0003_0000, 4'b1000, "reset in slot3 wait");
    slv_wait[3] = 0;
    idle(2);
    xfer(1'b1, 32'h0003_0004, HTRANS_NONSEQ, 4'b1000, 32'hC3C3_0003, HRESP_OKAY, 0, HRESP_OKAY, "slot3 after reset");
    idle(2);

`ifdef AHB_DEC_TIMEOUT_EN
    // slot 0 hangs: 8 slave wait cycles, then ERR1/ERR2; slot 1 afterwards is normal
    slv_hang[0] = 1'b1;
    xfer(1'b1, 32'h0000_0010, HTRANS_NONSEQ, 4'b0001, 32'h0, HRESP_ERROR, 9, HRESP_ERROR, "timeout slot0");
    xfer(1'b1, 32'h0001_0000, HTRANS_NONSEQ, 4'b0010, 32'h0000_B111, HRESP_OKAY, 0, HRESP_OKAY, "slot1 after timeout");
    idle(3);
    slv_hang[0] = 1'b0;
    idle(2);
`endif

    idle(4);
    check("drain expected queue", 32'(exp_q.size()), 32'd0);
    check("drain pending data phase", 32'(mon_vld), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
